// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-add cell, registered carry, start/busy/done handshake.
// Latency: done in the cycle after edge WIDTH following acceptance; start is ignored unless idle.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_cin
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nxt, last;

  assign s_bit   = sh_a[0] ^ sh_b[0] ^ carry;
  assign c_nxt   = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign last    = (cnt == LAST);
  assign res_nxt = {s_bit, res[WIDTH-1:1]};

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign bit_a   = busy & sh_a[0];
  assign bit_b   = busy & sh_b[0];
  assign bit_cin = busy & carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          res   <= res_nxt;
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          carry <= c_nxt;
          cnt   <= cnt + CW'(1);
          // Publish the result on the final bit's edge so it is valid alongside done.
          if (last) begin
            sum       <= res_nxt;
            carry_out <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential adder that adds two WIDTH-bit operands one bit per clock, LSB first, using a single full-add cell with a registered carry.
- Sits directly downstream of the half/full-adder cells in the adder library. It reuses the same sum/carry equations, iterated over time instead of replicated in space.
- Start/busy/done handshake to an upstream requester. Result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range 2 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  operation request. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse when sum/carry_out have just been updated.
- sum  output  WIDTH  result of the last completed addition, modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1 of the last completed addition.
- bit_a  output  1  operand-A bit presented to the adder cell this cycle. 0 when not busy.
- bit_b  output  1  operand-B bit presented to the adder cell this cycle. 0 when not busy.
- bit_cin  output  1  carry-in presented to the adder cell this cycle. 0 when not busy.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, carry_out=0, bit_a/bit_b/bit_cin=0; internal shift registers, carry register and bit counter cleared. Takes effect immediately, including mid-operation. The in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0, do the following, then go to RUN:
  - load shift registers with a and b;
  - clear carry register and counter;
  - clear internal result shift register.
  Otherwise stay in IDLE.
- RUN, at each of edges E1..E_WIDTH:
  - compute s = a_lsb ^ b_lsb ^ c and c_next = majority(a_lsb, b_lsb, c);
  - shift s into the result register from the MSB end;
  - shift both operand registers right by one;
  - store c_next; increment counter.
- RUN exit: at E_WIDTH (counter reaches WIDTH-1 before the edge) go to DONE. In the same edge, copy the complete result to sum and the final carry to carry_out.
- DONE: done=1 for exactly one cycle. At the next edge go to IDLE unconditionally.
- busy=1 exactly when state=RUN. Busy is therefore high for WIDTH cycles.
- Latency: done is high in the cycle after E_WIDTH. Minimum request-to-request spacing is WIDTH+2 cycles.
- bit_a/bit_b/bit_cin are combinational from the operand-register LSBs and the carry register while in RUN. They are forced to 0 otherwise.
- sum/carry_out change only at E_WIDTH of a completed operation. They hold their value through IDLE, RUN and DONE otherwise.
- start in RUN or DONE is ignored: no queuing and no restart.
- start held continuously high is accepted at the first IDLE cycle after each DONE, giving back-to-back operations.
- a/b changes after E0 have no effect on the operation in flight.
- Overflow: the sum wraps modulo 2^WIDTH and the overflow is reported only through carry_out. No signed interpretation.

Test Plan:
- WIDTH=8, after reset with no start -> sum=0x00, carry_out=0, busy=0, done=0 for 20 cycles.
- a=0xA5, b=0x5A, one-cycle start -> busy high for exactly 8 cycles; done pulses one cycle later; sum=0xFF, carry_out=0. The bit_cin sequence is all 0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. bit_cin reads 0 in the first RUN cycle and 1 in the remaining 7.
- a=0x80, b=0x80 -> sum=0x00, carry_out=1. Then a=0x00, b=0x00 -> sum=0x00, carry_out=0. Previous result holds until the second op's E_WIDTH.
- start held high, a=0x03, b=0x04 then changed to 0x10/0x20 mid-RUN and start pulsed during RUN/DONE:
  - first result is 0x07;
  - the extra pulses are ignored;
  - the next operation begins exactly 10 cycles after the first E0 and yields 0x30.
- rst_n pulsed low for 1 ns in the 4th RUN cycle of a=0x7F, b=0x01 -> all outputs 0 immediately; no done pulse. A fresh start afterwards gives sum=0x80, carry_out=0.
